// File: rtl/ltl_report_collector.sv
// Report collector for an Automata_ltl cluster: timestamps report vectors with the
// symbol index and buffers them in a small FIFO drained over valid/ready.
module ltl_report_collector #(
  parameter int N_REPORTS = 4,
  parameter int IDX_W     = 16,
  parameter int DEPTH     = 8,
  parameter int DROP_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     clear,
  input  logic [N_REPORTS-1:0]     report_vec,
  output logic                     rpt_valid,
  input  logic                     rpt_ready,
  output logic [IDX_W-1:0]         rpt_idx,
  output logic [N_REPORTS-1:0]     rpt_bits,
  output logic [IDX_W-1:0]         sym_idx,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic [IDX_W-1:0]     idx_mem  [DEPTH];
  logic [N_REPORTS-1:0] bits_mem [DEPTH];

  logic empty;
  logic full;
  logic push_req;
  logic pop;
  logic do_push;
  logic drop;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_req = run & (|report_vec);
  assign pop      = ~empty & rpt_ready;
  assign do_push  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  assign rpt_valid = ~empty;
  assign rpt_idx   = idx_mem[rd_ptr[AW-1:0]];
  assign rpt_bits  = bits_mem[rd_ptr[AW-1:0]];
  assign occupancy = wr_ptr - rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is reset so the head outputs read zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_mem  <= '{default: '0};
      bits_mem <= '{default: '0};
    end else if (do_push && !clear) begin
      idx_mem[wr_ptr[AW-1:0]]  <= sym_idx;
      bits_mem[wr_ptr[AW-1:0]] <= report_vec;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_idx <= '0;
    end else if (clear) begin
      sym_idx <= '0;
    end else if (run) begin
      sym_idx <= sym_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ltl_report_collector.sv
// Randomised and directed bench for ltl_report_collector; a queue-based model predicts
// the FIFO, counters and flags, checked every cycle on two widths of symbol index.
module tb_ltl_report_collector;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        clear = 1'b0;
  logic        rpt_ready = 1'b0;
  logic [3:0]  report_vec = 4'h0;

  logic        rpt_valid_a, overflow_a;
  logic [15:0] rpt_idx_a, sym_idx_a;
  logic [3:0]  rpt_bits_a, occupancy_a;
  logic [7:0]  drop_cnt_a;

  logic        rpt_valid_b, overflow_b;
  logic [3:0]  rpt_idx_b, sym_idx_b;
  logic [3:0]  rpt_bits_b, occupancy_b;
  logic [7:0]  drop_cnt_b;

  ltl_report_collector #(.N_REPORTS(4), .IDX_W(16), .DEPTH(DEPTH), .DROP_W(8)) dut_a (
    .clk(clk), .reset(reset), .run(run), .clear(clear), .report_vec(report_vec),
    .rpt_valid(rpt_valid_a), .rpt_ready(rpt_ready), .rpt_idx(rpt_idx_a), .rpt_bits(rpt_bits_a),
    .sym_idx(sym_idx_a), .occupancy(occupancy_a), .overflow(overflow_a), .drop_cnt(drop_cnt_a)
  );

  ltl_report_collector #(.N_REPORTS(4), .IDX_W(4), .DEPTH(DEPTH), .DROP_W(8)) dut_b (
    .clk(clk), .reset(reset), .run(run), .clear(clear), .report_vec(report_vec),
    .rpt_valid(rpt_valid_b), .rpt_ready(rpt_ready), .rpt_idx(rpt_idx_b), .rpt_bits(rpt_bits_b),
    .sym_idx(sym_idx_b), .occupancy(occupancy_b), .overflow(overflow_b), .drop_cnt(drop_cnt_b)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  typedef struct {
    int unsigned idx;
    logic [3:0]  bits;
  } ent_t;

  ent_t        m_q[$];
  int unsigned m_sym = 0;
  bit          m_ovf = 1'b0;
  int          m_drop = 0;
  bit          m_pop;
  bit          m_was_full;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an unbounded symbol counter and a queue of stamped events.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_sym = 0;
      m_ovf = 1'b0;
      m_drop = 0;
    end else if (clear) begin
      m_q.delete();
      m_sym = 0;
      m_ovf = 1'b0;
      m_drop = 0;
    end else begin
      m_was_full = (m_q.size() == DEPTH);
      m_pop = (m_q.size() > 0) && rpt_ready;
      if (m_pop) void'(m_q.pop_front());
      if (run && report_vec != 4'h0) begin
        if (!m_was_full || m_pop) m_q.push_back('{m_sym, report_vec});
        else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
      if (run) m_sym++;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check_output("valid_a", 32'(rpt_valid_a), 32'(m_q.size() != 0));
      check_output("valid_b", 32'(rpt_valid_b), 32'(m_q.size() != 0));
      check_output("occ_a", 32'(occupancy_a), 32'(m_q.size()));
      check_output("occ_b", 32'(occupancy_b), 32'(m_q.size()));
      check_output("sym_a", 32'(sym_idx_a), m_sym & 32'hFFFF);
      check_output("sym_b", 32'(sym_idx_b), m_sym & 32'hF);
      check_output("ovf_a", 32'(overflow_a), 32'(m_ovf));
      check_output("ovf_b", 32'(overflow_b), 32'(m_ovf));
      check_output("drop_a", 32'(drop_cnt_a), 32'(m_drop));
      check_output("drop_b", 32'(drop_cnt_b), 32'(m_drop));
      if (m_q.size() != 0) begin
        check_output("idx_a", 32'(rpt_idx_a), m_q[0].idx & 32'hFFFF);
        check_output("idx_b", 32'(rpt_idx_b), m_q[0].idx & 32'hF);
        check_output("bits_a", 32'(rpt_bits_a), 32'(m_q[0].bits));
        check_output("bits_b", 32'(rpt_bits_b), 32'(m_q[0].bits));
      end
    end
  end

  // Inputs change 2 time units after the rising edge, well clear of both edges.
  task automatic apply_stimulus(input logic r, input logic [3:0] v, input logic rd, input logic c);
    run = r;
    report_vec = v;
    rpt_ready = rd;
    clear = c;
    @(posedge clk);
    #2;
  endtask

  int exp_drain[8];
  int ready_pct;

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check_output("rst_valid", 32'(rpt_valid_a), 32'd0);
    check_output("rst_occ", 32'(occupancy_a), 32'd0);
    check_output("rst_sym", 32'(sym_idx_a), 32'd0);
    check_output("rst_idx", 32'(rpt_idx_a), 32'd0);
    check_output("rst_drop", 32'(drop_cnt_a), 32'd0);
    reset = 1'b0;
    check_en = 1'b1;

    apply_stimulus(1, 4'h0, 1, 0);
    apply_stimulus(1, 4'h0, 1, 0);
    apply_stimulus(1, 4'h2, 1, 0);
    check_output("t1_valid", 32'(rpt_valid_a), 32'd1);
    check_output("t1_idx", 32'(rpt_idx_a), 32'd2);
    check_output("t1_bits", 32'(rpt_bits_a), 32'h2);
    apply_stimulus(1, 4'h0, 1, 0);
    check_output("t1_valid_gone", 32'(rpt_valid_a), 32'd0);
    apply_stimulus(1, 4'h0, 1, 0);
    check_output("t1_sym", 32'(sym_idx_a), 32'd5);

    repeat (10) apply_stimulus(0, 4'hF, 1, 0);
    check_output("t2_occ", 32'(occupancy_a), 32'd0);
    check_output("t2_sym", 32'(sym_idx_a), 32'd5);

    apply_stimulus(0, 4'h0, 0, 1);
    for (int i = 0; i < 10; i++) apply_stimulus(1, 4'($urandom_range(1, 15)), 0, 0);
    check_output("t3_occ", 32'(occupancy_a), 32'd8);
    check_output("t3_ovf", 32'(overflow_a), 32'd1);
    check_output("t3_drop", 32'(drop_cnt_a), 32'd2);
    check_output("t3_head", 32'(rpt_idx_a), 32'd0);

    apply_stimulus(1, 4'h9, 1, 0);
    check_output("t4_occ", 32'(occupancy_a), 32'd8);
    check_output("t4_drop", 32'(drop_cnt_a), 32'd2);
    exp_drain = '{1, 2, 3, 4, 5, 6, 7, 10};
    for (int i = 0; i < 8; i++) begin
      check_output("t4_drain_idx", 32'(rpt_idx_a), 32'(exp_drain[i]));
      if (i == 7) check_output("t4_tail_bits", 32'(rpt_bits_a), 32'h9);
      apply_stimulus(0, 4'h0, 1, 0);
    end
    check_output("t4_empty", 32'(rpt_valid_a), 32'd0);

    apply_stimulus(0, 4'h0, 0, 1);
    for (int c = 0; c < 20; c++) apply_stimulus(1, (c == 15 || c == 16) ? 4'h5 : 4'h0, 0, 0);
    check_output("t5_idx_b", 32'(rpt_idx_b), 32'd15);
    check_output("t5_idx_a", 32'(rpt_idx_a), 32'd15);
    check_output("t5_occ", 32'(occupancy_b), 32'd2);
    check_output("t5_ovf", 32'(overflow_b), 32'd0);
    check_output("t5_sym_b", 32'(sym_idx_b), 32'd4);
    apply_stimulus(0, 4'h0, 1, 0);
    check_output("t5_idx_b_wrap", 32'(rpt_idx_b), 32'd0);
    check_output("t5_idx_a_next", 32'(rpt_idx_a), 32'd16);

    apply_stimulus(0, 4'h0, 0, 1);
    repeat (9) apply_stimulus(1, 4'h1, 0, 0);
    repeat (4) apply_stimulus(0, 4'h0, 1, 0);
    check_output("t6_half", 32'(occupancy_a), 32'd4);
    check_output("t6_drop_pre", 32'(drop_cnt_a), 32'd1);
    apply_stimulus(1, 4'h3, 0, 1);
    check_output("t6_valid", 32'(rpt_valid_a), 32'd0);
    check_output("t6_occ", 32'(occupancy_a), 32'd0);
    check_output("t6_sym", 32'(sym_idx_a), 32'd0);
    check_output("t6_drop", 32'(drop_cnt_a), 32'd0);
    check_output("t6_ovf", 32'(overflow_a), 32'd0);

    repeat (270) apply_stimulus(1, 4'h8, 0, 0);
    check_output("sat_drop", 32'(drop_cnt_a), 32'd255);
    check_output("sat_ovf", 32'(overflow_a), 32'd1);
    apply_stimulus(0, 4'h0, 0, 1);

    apply_stimulus(1, 4'h1, 0, 0);
    check_output("ar_pre_valid", 32'(rpt_valid_a), 32'd1);
    #1 reset = 1'b1;
    #1;
    check_output("ar_valid", 32'(rpt_valid_a), 32'd0);
    check_output("ar_occ", 32'(occupancy_a), 32'd0);
    check_output("ar_sym", 32'(sym_idx_a), 32'd0);
    reset = 1'b0;

    for (int blk = 0; blk < 15; blk++) begin
      ready_pct = $urandom_range(5, 95);
      for (int i = 0; i < 200; i++) begin
        apply_stimulus(($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom),
                       ($urandom_range(0, 99) < ready_pct),
                       ($urandom_range(0, 149) == 0));
      end
    end

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
